// File: rtl/id_pipe_fwd.sv
// Decode stage with a one-entry holding register. Operands are resolved from
// the bypass network, and the stage interlocks on load-use hazards.
module id_pipe_fwd #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NBYP = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_inst,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [NBYP-1:0]      byp_we,
    input  logic [NBYP-1:0]      byp_load,
    input  logic [NBYP*AW-1:0]   byp_waddr,
    input  logic [NBYP*XLEN-1:0] byp_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_inst,
    output logic [XLEN-1:0]      out_src1,
    output logic [XLEN-1:0]      out_src2,
    output logic                 stallreq,
    output logic                 br_taken,
    output logic [31:0]          br_target,
    output logic [31:0]          stall_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    typedef struct packed {
        logic            load;
        logic [XLEN-1:0] value;
    } operand_t;

    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic [5:0]    opcode;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          use_rs;
    logic          use_rt;
    operand_t      op1;
    operand_t      op2;
    logic          hazard;
    logic          fire;
    logic          is_branch;
    logic          br_cond;
    logic [31:0]   br_offset;

    // Register zero never forwards and never interlocks. The loop walks from the
    // oldest source to the youngest so the lowest-index match is the last write.
    function automatic operand_t resolve(
        input logic [AW-1:0]        addr,
        input logic [XLEN-1:0]      rf_val,
        input logic [NBYP-1:0]      we,
        input logic [NBYP-1:0]      ld,
        input logic [NBYP*AW-1:0]   waddr,
        input logic [NBYP*XLEN-1:0] wdata
    );
        operand_t res;
        res = '0;
        if (addr != '0) begin
            res.value = rf_val;
            for (int i = NBYP - 1; i >= 0; i--) begin
                if (we[i] && (waddr[i*AW +: AW] == addr)) begin
                    res.value = wdata[i*XLEN +: XLEN];
                    res.load  = ld[i];
                end
            end
        end
        return res;
    endfunction

    assign opcode  = hold_inst_q[31:26];
    assign rs_addr = AW'(hold_inst_q[25:21]);
    assign rt_addr = AW'(hold_inst_q[20:16]);

    assign rf_raddr1 = rs_addr;
    assign rf_raddr2 = rt_addr;

    assign use_rs = !((opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_LUI));
    assign use_rt = (opcode == OP_SPECIAL) || (opcode == OP_BEQ) ||
                    (opcode == OP_BNE) || (opcode[5:3] == 3'b101);

    assign op1 = resolve(rs_addr, rf_rdata1, byp_we, byp_load, byp_waddr, byp_wdata);
    assign op2 = resolve(rt_addr, rf_rdata2, byp_we, byp_load, byp_waddr, byp_wdata);

    assign hazard    = hold_valid_q && ((use_rs && op1.load) || (use_rt && op2.load));
    assign out_valid = hold_valid_q && !hazard;
    assign stallreq  = hold_valid_q && hazard;
    assign fire      = out_valid && out_ready;
    assign in_ready  = !hold_valid_q || fire;

    assign out_pc   = out_valid ? hold_pc_q   : 32'd0;
    assign out_inst = out_valid ? hold_inst_q : 32'd0;
    assign out_src1 = out_valid ? op1.value   : '0;
    assign out_src2 = out_valid ? op2.value   : '0;

    // Branches compare the forwarded operands so a just-produced value is honoured.
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign br_cond   = (opcode == OP_BEQ) ? (op1.value == op2.value)
                                          : (op1.value != op2.value);
    assign br_offset = {{14{hold_inst_q[15]}}, hold_inst_q[15:0], 2'b00};
    assign br_taken  = fire && !flush && is_branch && br_cond;
    assign br_target = br_taken ? (hold_pc_q + 32'd4 + br_offset) : 32'd0;

    assign stall_cnt = stall_cnt_q;

    // NOTE: every signal gets a default at the top of always_comb so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            hold_valid_d = 1'b1;
            hold_pc_d    = in_pc;
            hold_inst_d  = in_inst;
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end

        if (stallreq && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_pc_q    <= 32'd0;
            hold_inst_q  <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_pipe_fwd.sv
// Directed bench for id_pipe_fwd: forwarding priority, load-use interlock,
// branch resolution, flush/backpressure and reset behaviour.
module tb_id_pipe_fwd;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NBYP = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_pc;
    logic [31:0]          in_inst;
    logic [AW-1:0]        rf_raddr1;
    logic [AW-1:0]        rf_raddr2;
    logic [XLEN-1:0]      rf_rdata1;
    logic [XLEN-1:0]      rf_rdata2;
    logic [NBYP-1:0]      byp_we;
    logic [NBYP-1:0]      byp_load;
    logic [NBYP*AW-1:0]   byp_waddr;
    logic [NBYP*XLEN-1:0] byp_wdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_pc;
    logic [31:0]          out_inst;
    logic [XLEN-1:0]      out_src1;
    logic [XLEN-1:0]      out_src2;
    logic                 stallreq;
    logic                 br_taken;
    logic [31:0]          br_target;
    logic [31:0]          stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    id_pipe_fwd #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NBYP(NBYP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .byp_we(byp_we), .byp_load(byp_load), .byp_waddr(byp_waddr), .byp_wdata(byp_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_src1(out_src1), .out_src2(out_src2),
        .stallreq(stallreq), .br_taken(br_taken), .br_target(br_target),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // after a further unit of settling, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byp(input int i, input logic we, input logic ld,
                           input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        byp_we[i]                = we;
        byp_load[i]              = ld;
        byp_waddr[i*AW +: AW]    = a;
        byp_wdata[i*XLEN +: XLEN] = d;
    endtask

    task automatic clear_byp();
        byp_we    = '0;
        byp_load  = '0;
        byp_waddr = '0;
        byp_wdata = '0;
    endtask

    task automatic load_inst(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; out_ready = 1'b1;
        clear_byp();

        // Reset state
        tick(); tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall_cnt", stall_cnt,      32'd0);
        check("rst_br_target", br_target,      32'd0);
        check("rst_raddr1",    32'(rf_raddr1), 32'd0);
        rst = 1'b0;
        #1;

        // Bypass priority: ADDU $3,$1,$2, byp0 and byp2 both write $1
        set_byp(0, 1'b1, 1'b0, 5'd1, 32'hA);
        set_byp(2, 1'b1, 1'b0, 5'd1, 32'hC);
        rf_rdata1 = 32'h77; rf_rdata2 = 32'h5;
        load_inst(32'h40, 32'h0022_1821);
        check("byp_out_valid", 32'(out_valid), 32'd1);
        check("byp_out_pc",    out_pc,         32'h40);
        check("byp_out_inst",  out_inst,       32'h0022_1821);
        check("byp_src1",      out_src1,       32'hA);
        check("byp_src2",      out_src2,       32'h5);
        check("byp_raddr2",    32'(rf_raddr2), 32'd2);
        byp_we[0] = 1'b0;
        #1;
        check("byp_src1_older", out_src1, 32'hC);
        tick();
        check("fire_clears",   32'(out_valid), 32'd0);
        check("fire_src1_zero", out_src1,      32'd0);

        // Load-use on rt
        clear_byp();
        set_byp(0, 1'b1, 1'b1, 5'd2, 32'h0);
        load_inst(32'h80, 32'h0022_2021);
        check("lu_out_valid", 32'(out_valid), 32'd0);
        check("lu_stallreq",  32'(stallreq),  32'd1);
        check("lu_in_ready",  32'(in_ready),  32'd0);
        check("lu_cnt0",      stall_cnt,      32'd0);
        in_valid = 1'b1; in_pc = 32'h999; in_inst = 32'h0000_0021;
        tick();
        check("lu_cnt1", stall_cnt, 32'd1);
        tick();
        check("lu_cnt2", stall_cnt, 32'd2);
        in_valid = 1'b0;
        set_byp(0, 1'b1, 1'b0, 5'd2, 32'h55);
        #1;
        check("lu_release_valid", 32'(out_valid), 32'd1);
        check("lu_entry_kept",    out_pc,         32'h80);
        check("lu_src2",          out_src2,       32'h55);
        check("lu_stallreq_off",  32'(stallreq),  32'd0);
        tick();
        check("lu_cnt_frozen", stall_cnt,      32'd2);
        check("lu_drained",    32'(out_valid), 32'd0);

        // Store uses rt
        set_byp(0, 1'b1, 1'b1, 5'd2, 32'h0);
        load_inst(32'h90, 32'hAC22_0000);
        check("sw_stall", 32'(stallreq), 32'd1);
        byp_load[0] = 1'b0;
        #1;
        check("sw_release", 32'(out_valid), 32'd1);
        tick();

        // Zero register and unused fields
        set_byp(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        load_inst(32'hA0, 32'h3C00_1234);
        check("lui_no_stall", 32'(stallreq),  32'd0);
        check("lui_valid",    32'(out_valid), 32'd1);
        tick();
        set_byp(0, 1'b1, 1'b1, 5'd1, 32'hDEAD);
        load_inst(32'hA4, 32'h0822_0000);
        check("j_no_stall", 32'(stallreq),  32'd0);
        check("j_valid",    32'(out_valid), 32'd1);
        tick();
        set_byp(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        rf_rdata1 = 32'h33; rf_rdata2 = 32'h44;
        load_inst(32'hA8, 32'h0000_2821);
        check("r0_valid", 32'(out_valid), 32'd1);
        check("r0_src1",  out_src1,       32'd0);
        check("r0_src2",  out_src2,       32'd0);
        tick();

        // BEQ resolved through byp1 while raw regfile data differ
        clear_byp();
        rf_rdata1 = 32'h1234; rf_rdata2 = 32'h9;
        set_byp(1, 1'b1, 1'b0, 5'd1, 32'h9);
        out_ready = 1'b0;
        load_inst(32'h100, 32'h1022_FFFF);
        check("beq_held_valid",  32'(out_valid), 32'd1);
        check("beq_held_taken",  32'(br_taken),  32'd0);
        check("beq_held_target", br_target,      32'd0);
        out_ready = 1'b1;
        #1;
        check("beq_taken",  32'(br_taken), 32'd1);
        check("beq_target", br_target,     32'h100);
        tick();
        check("beq_pulse_end", 32'(br_taken), 32'd0);

        // Flush suppresses a taken branch
        load_inst(32'h100, 32'h1022_FFFF);
        flush = 1'b1;
        #1;
        check("flush_br_taken", 32'(br_taken), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_cleared", 32'(out_valid), 32'd0);

        // BNE taken with positive offset, then BNE not taken via bypass
        clear_byp();
        rf_rdata1 = 32'h1; rf_rdata2 = 32'h2;
        load_inst(32'h200, 32'h1422_0010);
        check("bne_taken",  32'(br_taken), 32'd1);
        check("bne_target", br_target,     32'h244);
        tick();
        set_byp(0, 1'b1, 1'b0, 5'd2, 32'h1);
        load_inst(32'h208, 32'h1422_0010);
        check("bne_not_taken", 32'(br_taken), 32'd0);
        check("bne_nt_target", br_target,     32'd0);
        tick();

        // Backpressure for three cycles, then flush beats a same-cycle load
        clear_byp();
        rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        out_ready = 1'b0;
        load_inst(32'h300, 32'h0022_2021);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_pc",       out_pc,        32'h300);
            check("bp_src1",     out_src1,      32'h11);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_cnt",      stall_cnt,     32'd2);
        end
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h400; in_inst = 32'h0000_0021;
        out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_valid",    32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready),  32'd1);
        check("fl_pc",       out_pc,         32'd0);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h500;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_empty_drop", 32'(out_valid), 32'd0);

        // Reset during an interlock, with in_valid asserted
        set_byp(0, 1'b1, 1'b1, 5'd2, 32'h0);
        load_inst(32'h600, 32'h0022_2021);
        tick(); tick();
        check("ms_cnt", stall_cnt, 32'd4);
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h700; in_inst = 32'h0022_2021;
        tick();
        check("ms_rst_in_ready", 32'(in_ready),  32'd1);
        check("ms_rst_stallreq", 32'(stallreq),  32'd0);
        check("ms_rst_cnt",      stall_cnt,      32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("ms_out_valid", 32'(out_valid), 32'd0);
        check("ms_in_ready",  32'(in_ready),  32'd1);
        tick();
        check("ms_cnt_after", stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_pipe_fwd.md
ID_PIPE_FWD -- requirements
Module: id_pipe_fwd

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; NREG, default 32, register count; AW, default $clog2(NREG), register address width; NBYP, default 3, bypass source count, where index 0 is the youngest (EX).
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1 clock; rst in 1 reset, synchronous, active-high.
- flush in 1 discard held instruction.
- in_valid in 1 IF offers an instruction.
- in_ready out 1 stage can accept.
- in_pc in 32 fetch PC.
- in_inst in 32 instruction word.
- rf_raddr1 out AW regfile read address, driven from inst[25:21].
- rf_raddr2 out AW regfile read address, driven from inst[20:16].
- rf_rdata1 in XLEN combinational regfile read data.
- rf_rdata2 in XLEN combinational regfile read data.
- byp_we in NBYP per-source write enable.
- byp_load in NBYP per-source result-not-yet-available flag (load in flight).
- byp_waddr in NBYP*AW per-source destination; source i occupies bits [i*AW +: AW].
- byp_wdata in NBYP*XLEN per-source result; source i occupies bits [i*XLEN +: XLEN].
- out_valid out 1 decoded instruction with resolved operands to EX.
- out_ready in 1 EX accepts.
- out_pc out 32; out_inst out 32; out_src1 out XLEN; out_src2 out XLEN.
- stallreq out 1 load-use interlock active.
- br_taken out 1 branch redirect pulse.
- br_target out 32 redirect address.
- stall_cnt out 32 interlock-cycle performance counter.

Function
REQ-003 The block SHALL hold a one-entry register {hold_valid, hold_pc, hold_inst}.
REQ-004 in_ready SHALL equal !hold_valid | (out_valid & out_ready).
REQ-005 On in_valid & in_ready the block SHALL load the entry and set hold_valid=1; the instruction appears at the outputs in the next cycle (1-cycle latency).
REQ-006 On out fire without a new load, the block SHALL clear hold_valid.
REQ-007 flush SHALL clear hold_valid at the next edge, take priority over a same-cycle load, and suppress br_taken in that cycle.
REQ-008 Operand use SHALL be decoded as follows: rs is used by all opcodes except J(000010), JAL(000011) and LUI(001111); rt is used by SPECIAL(000000), BEQ(000100), BNE(000101) and stores (opcode 101xxx).
REQ-009 Operand resolution SHALL be per source operand: value is 0 if addr==0; otherwise the lowest-index i with byp_we[i] & byp_waddr[i]==addr supplies byp_wdata[i]; otherwise the value is rf_rdata.
REQ-010 A hazard SHALL exist when hold_valid is set, the operand is used, and its selected (lowest-index) match has byp_load[i]=1.
REQ-011 out_valid SHALL equal hold_valid & !hazard.
REQ-012 stallreq SHALL equal hold_valid & hazard.
REQ-013 While a hazard exists, the entry SHALL be held unchanged and in_ready SHALL be 0.
REQ-014 out_pc, out_inst, out_src1 and out_src2 SHALL be combinational from the entry and the resolved operands, and SHALL be 0 when out_valid=0.
REQ-015 Branch evaluation SHALL use only resolved operands (never raw regfile data): BEQ is taken if src1==src2; BNE is taken if src1!=src2.
REQ-016 br_taken SHALL be asserted only in the cycle a taken BEQ/BNE fires (out_valid & out_ready).
REQ-017 br_target SHALL equal hold_pc+4+(sign-extended imm16<<2) with 32-bit wrap-around, and SHALL be 0 when br_taken=0.
REQ-018 The delay slot SHALL NOT be squashed by this block.
REQ-019 stall_cnt SHALL increment in each cycle stallreq=1 and saturate at 32'hFFFF_FFFF.
REQ-020 When out_ready=0 with no hazard, the entry SHALL be held; stall_cnt SHALL NOT increment.

Reset
REQ-021 While rst=1, the block SHALL clear hold_valid, hold_pc, hold_inst and stall_cnt to 0.
REQ-022 All outputs SHALL be 0 during and after reset, except in_ready=1.
REQ-023 Reset SHALL override flush and in_valid.
REQ-024 A reset asserted mid-interlock SHALL discard the held instruction.

Verification
REQ-025 Bypass priority: inst ADDU $3,$1,$2 with byp0={we=1,addr=1,data=0xA}, byp2={we=1,addr=1,data=0xC}, rf_rdata2=5 -> out_src1=0xA, out_src2=5.
REQ-026 Load-use: byp0={we=1,load=1,addr=2} with held inst using rt=2 -> out_valid=0, stallreq=1, in_ready=0, stall_cnt +1 per cycle; clearing load -> out_valid=1 the next cycle.
REQ-027 Zero register and unused fields: LUI $0 with byp0 addr=0 load=1 -> no stall; J with rs-field match having load=1 -> no stall.
REQ-028 Branch: BEQ at pc 0x100, imm=0xFFFF, operands equal via byp1 -> br_taken=1 in the fire cycle only, br_target=0x100.
REQ-029 Flush and backpressure: hold entry with out_ready=0 for 3 cycles -> outputs stable; assert flush with in_valid=1 -> hold_valid=0 next cycle and the new instruction is dropped.
REQ-030 Reset mid-stall: rst during interlock -> stall_cnt=0, out_valid=0, in_ready=1 the next cycle.
